vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 182 ++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA-style timing generator: h/v counters, registered syncs, position and pulses,
// with IDLE/RUN/DRAIN run control. Define VGA_TIMING_FRAME_CNT_EN to add frame_cnt.
module vga_timing_gen #(
  parameter int unsigned CW         = 11,
  parameter int unsigned H_DISPLAY  = 640,
  parameter int unsigned H_FPORCH   = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BPORCH   = 48,
  parameter int unsigned V_DISPLAY  = 480,
  parameter int unsigned V_FPORCH   = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BPORCH   = 33,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_en,
  input  logic          run,
  output logic          h_sync,
  output logic          v_sync,
  output logic          video_on,
  output logic [CW-1:0] pos_x,
  output logic [CW-1:0] pos_y,
  output logic          line_start,
  output logic          frame_start,
  output logic          running
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FPORCH + H_SYNC + H_BPORCH;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FPORCH + V_SYNC + V_BPORCH;

  localparam int unsigned H_SYNC_START = H_DISPLAY + H_FPORCH;
  localparam int unsigned H_SYNC_STOP  = H_DISPLAY + H_FPORCH + H_SYNC;
  localparam int unsigned V_SYNC_START = V_DISPLAY + V_FPORCH;
  localparam int unsigned V_SYNC_STOP  = V_DISPLAY + V_FPORCH + V_SYNC;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  if (64'(H_TOTAL) > (64'd1 << CW)) begin : g_h_total_check
    $error("vga_timing_gen: H_TOTAL %0d does not fit in CW=%0d bits", H_TOTAL, CW);
  end
  if (64'(V_TOTAL) > (64'd1 << CW)) begin : g_v_total_check
    $error("vga_timing_gen: V_TOTAL %0d does not fit in CW=%0d bits", V_TOTAL, CW);
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic          at_wrap;
  logic          h_in_sync;
  logic          v_in_sync;
  logic          h_in_disp;
  logic          v_in_disp;

  logic [CW-1:0] pos_x_d;
  logic [CW-1:0] pos_y_d;
  logic          h_sync_d;
  logic          v_sync_d;
  logic          video_on_d;
  logic          line_start_d;
  logic          frame_start_d;
  logic          running_d;

  // Counters sit at (0,0) while active only once the last position has been output.
  assign at_wrap   = (h_cnt == '0) && (v_cnt == '0);
  assign h_in_sync = (32'(h_cnt) >= H_SYNC_START) && (32'(h_cnt) < H_SYNC_STOP);
  assign v_in_sync = (32'(v_cnt) >= V_SYNC_START) && (32'(v_cnt) < V_SYNC_STOP);
  assign h_in_disp = 32'(h_cnt) < H_DISPLAY;
  assign v_in_disp = 32'(v_cnt) < V_DISPLAY;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (pix_en) begin
      unique case (state)
        IDLE: begin
          if (run) state_nxt = RUN;
        end
        RUN, DRAIN: begin
          if (run)          state_nxt = RUN;
          else if (at_wrap) state_nxt = IDLE;
          else              state_nxt = DRAIN;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Decode of the values the next pix_en edge loads into the output registers.
  always_comb begin
    pos_x_d       = '0;
    pos_y_d       = '0;
    h_sync_d      = ~H_SYNC_POL;
    v_sync_d      = ~V_SYNC_POL;
    video_on_d    = 1'b0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    running_d     = 1'b0;
    if (state_nxt != IDLE) begin
      pos_x_d       = h_cnt;
      pos_y_d       = v_cnt;
      h_sync_d      = h_in_sync ? H_SYNC_POL : ~H_SYNC_POL;
      v_sync_d      = v_in_sync ? V_SYNC_POL : ~V_SYNC_POL;
      video_on_d    = h_in_disp && v_in_disp;
      line_start_d  = (h_cnt == '0);
      frame_start_d = at_wrap;
      running_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (state_nxt == IDLE) begin
        h_cnt <= '0;
        v_cnt <= '0;
      end else if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CW'(1);
      end else begin
        h_cnt <= h_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_x       <= '0;
      pos_y       <= '0;
      h_sync      <= ~H_SYNC_POL;
      v_sync      <= ~V_SYNC_POL;
      video_on    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      running     <= 1'b0;
    end else begin
      line_start  <= pix_en && line_start_d;
      frame_start <= pix_en && frame_start_d;
      if (pix_en) begin
        pos_x    <= pos_x_d;
        pos_y    <= pos_y_d;
        h_sync   <= h_sync_d;
        v_sync   <= v_sync_d;
        video_on <= video_on_d;
        running  <= running_d;
      end
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (pix_en && frame_start_d) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (small/active-low, small/active-high, defaults)
// checked every cycle against a linear-position frame model.
module tb_vga_timing_gen;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic reset, pix_en, run;
  logic hs [NI];
  logic vs [NI];
  logic von [NI];
  logic ls [NI];
  logic fs [NI];
  logic rn [NI];
  logic [10:0] px [NI];
  logic [10:0] py [NI];
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] fc [NI];
  logic        fc_preset = 1'b0;
  int          m_fc [NI];
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Timing of each instance
  int h_disp [NI] = '{4, 4, 640};
  int h_fp   [NI] = '{2, 2, 16};
  int h_sw   [NI] = '{2, 2, 96};
  int h_bp   [NI] = '{2, 2, 48};
  int v_disp [NI] = '{3, 2, 480};
  int v_fp   [NI] = '{1, 1, 10};
  int v_sw   [NI] = '{2, 1, 2};
  int v_bp   [NI] = '{1, 1, 33};
  bit h_pol  [NI] = '{1'b0, 1'b1, 1'b0};
  bit v_pol  [NI] = '{1'b0, 1'b1, 1'b0};

  // Model: active flag plus linear position index within the frame
  bit m_act [NI];
  int m_p   [NI];
  bit m_ls  [NI];
  bit m_fs  [NI];

  always #5 clk = ~clk;

  vga_timing_gen #(
    .CW(11), .H_DISPLAY(4), .H_FPORCH(2), .H_SYNC(2), .H_BPORCH(2),
    .V_DISPLAY(3), .V_FPORCH(1), .V_SYNC(2), .V_BPORCH(1),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0)
  ) dut0 (
    .clk(clk), .reset(reset), .pix_en(pix_en), .run(run),
    .h_sync(hs[0]), .v_sync(vs[0]), .video_on(von[0]), .pos_x(px[0]), .pos_y(py[0]),
    .line_start(ls[0]), .frame_start(fs[0]), .running(rn[0])
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(fc[0])
`endif
  );

  vga_timing_gen #(
    .CW(11), .H_DISPLAY(4), .H_FPORCH(2), .H_SYNC(2), .H_BPORCH(2),
    .V_DISPLAY(2), .V_FPORCH(1), .V_SYNC(1), .V_BPORCH(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
  ) dut1 (
    .clk(clk), .reset(reset), .pix_en(pix_en), .run(run),
    .h_sync(hs[1]), .v_sync(vs[1]), .video_on(von[1]), .pos_x(px[1]), .pos_y(py[1]),
    .line_start(ls[1]), .frame_start(fs[1]), .running(rn[1])
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(fc[1])
`endif
  );

  vga_timing_gen dut2 (
    .clk(clk), .reset(reset), .pix_en(pix_en), .run(run),
    .h_sync(hs[2]), .v_sync(vs[2]), .video_on(von[2]), .pos_x(px[2]), .pos_y(py[2]),
    .line_start(ls[2]), .frame_start(fs[2]), .running(rn[2])
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(fc[2])
`endif
  );

  function automatic int h_tot(input int i);
    return h_disp[i] + h_fp[i] + h_sw[i] + h_bp[i];
  endfunction

  function automatic int f_tot(input int i);
    return h_tot(i) * (v_disp[i] + v_fp[i] + v_sw[i] + v_bp[i]);
  endfunction

  task automatic chk(input string nm, input int i, input longint unsigned got,
                     input longint unsigned want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s inst%0d: got 0x%0h, expected 0x%0h at %0t", nm, i, got, want, $time);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < NI; i++) begin
      bit a, l, f;
      int p;
      a = m_act[i]; p = m_p[i]; l = 1'b0; f = 1'b0;
      if (reset) begin
        a = 1'b0; p = 0;
`ifdef VGA_TIMING_FRAME_CNT_EN
        m_fc[i] <= 0;
`endif
      end else if (pix_en) begin
        if (!a) begin
          if (run) begin a = 1'b1; p = 0; end
        end else if (run) p = (p + 1) % f_tot(i);
        else if (p == f_tot(i) - 1) a = 1'b0;
        else p = p + 1;
        l = a && (p % h_tot(i) == 0);
        f = a && (p == 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
        if (fc_preset && i == 0) m_fc[i] <= f ? 0 : 16'hFFFF;
        else if (f) m_fc[i] <= (m_fc[i] + 1) % 65536;
`endif
      end
      m_act[i] <= a; m_p[i] <= p; m_ls[i] <= l; m_fs[i] <= f;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      int x, y;
      bit e_hs, e_vs, e_von;
      x = 0; y = 0; e_hs = ~h_pol[i]; e_vs = ~v_pol[i]; e_von = 1'b0;
      if (m_act[i]) begin
        x = m_p[i] % h_tot(i);
        y = m_p[i] / h_tot(i);
        if (x >= h_disp[i] + h_fp[i] && x < h_disp[i] + h_fp[i] + h_sw[i]) e_hs = h_pol[i];
        if (y >= v_disp[i] + v_fp[i] && y < v_disp[i] + v_fp[i] + v_sw[i]) e_vs = v_pol[i];
        e_von = (x < h_disp[i]) && (y < v_disp[i]);
      end
      chk("pos_x", i, px[i], x);
      chk("pos_y", i, py[i], y);
      chk("h_sync", i, hs[i], e_hs);
      chk("v_sync", i, vs[i], e_vs);
      chk("video_on", i, von[i], e_von);
      chk("running", i, rn[i], m_act[i]);
      chk("line_start", i, ls[i], m_ls[i]);
      chk("frame_start", i, fs[i], m_fs[i]);
`ifdef VGA_TIMING_FRAME_CNT_EN
      if (!fc_preset) chk("frame_cnt", i, fc[i], m_fc[i]);
`endif
    end
  end

  initial begin
    int k, ls2a, ls2b, fs0a, fs0b, lowcnt, lowx, vy0, hi1, hix1, vy1, lx, ly, waited;
    bit ok;
    reset = 1'b1; pix_en = 1'b0; run = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pos_x", 0, px[0], 0);
    chk("rst_h_sync", 0, hs[0], 1);
    chk("rst_h_sync_pol1", 1, hs[1], 0);
    chk("rst_v_sync_pol1", 1, vs[1], 0);
    chk("rst_running", 2, rn[2], 0);
    #2 reset = 1'b0; pix_en = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_no_run", 0, rn[0], 0);

    // Continuous strobe from IDLE
    run = 1'b1;
    ls2a = -1; ls2b = -1; fs0a = -1; fs0b = -1; lowcnt = 0; lowx = -1; vy0 = -1;
    hi1 = 0; hix1 = -1; vy1 = -1;
    for (k = 1; k <= 1700; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("first_fs", 2, fs[2], 1);
        chk("first_fs_x", 2, px[2], 0);
        chk("first_fs_y", 2, py[2], 0);
      end
      if (ls[2]) begin if (ls2a < 0) ls2a = k; else if (ls2b < 0) ls2b = k; end
      if (fs[0]) begin if (fs0a < 0) fs0a = k; else if (fs0b < 0) fs0b = k; end
      if (k <= 800 && !hs[2]) begin lowcnt++; if (lowx < 0) lowx = px[2]; end
      if (!vs[0] && vy0 < 0) vy0 = py[0];
      if (k <= 10 && hs[1]) begin hi1++; if (hix1 < 0) hix1 = px[1]; end
      if (vs[1] && vy1 < 0) vy1 = py[1];
    end
    chk("line_period", 2, ls2b - ls2a, 800);
    chk("hsync_low_cnt", 2, lowcnt, 96);
    chk("hsync_first_x", 2, lowx, 656);
    chk("frame_period", 0, fs0b - fs0a, 70);
    chk("vsync_first_y", 0, vy0, 4);
    chk("hsync_hi_cnt", 1, hi1, 2);
    chk("hsync_hi_x", 1, hix1, 6);
    chk("vsync_hi_y", 1, vy1, 3);

    // Strobe on every second clock
    ls2a = -1; ls2b = -1;
    for (k = 1; k <= 3400; k++) begin
      @(negedge clk);
      pix_en = ~pix_en;
      if (ls[2]) begin if (ls2a < 0) ls2a = k; else if (ls2b < 0) ls2b = k; end
    end
    chk("line_period_half", 2, ls2b - ls2a, 1600);

    // Drop run mid-frame: frame must finish through the last position
    pix_en = 1'b1; run = 1'b1;
    ok = 1'b0;
    for (waited = 0; waited < 200 && !ok; waited++) begin
      @(negedge clk);
      ok = rn[0] && px[0] == 1 && py[0] == 2;
    end
    chk("reach_1_2", 0, ok, 1);
    run = 1'b0;
    lx = -1; ly = -1; ok = 1'b0;
    for (waited = 0; waited < 200 && !ok; waited++) begin
      if (rn[0]) begin lx = px[0]; ly = py[0]; end
      @(negedge clk);
      ok = !rn[0];
    end
    chk("drain_done", 0, ok, 1);
    chk("drain_last_x", 0, lx, 9);
    chk("drain_last_y", 0, ly, 6);
    chk("idle_h_sync", 0, hs[0], 1);
    chk("idle_v_sync", 0, vs[0], 1);
    chk("idle_pos_x", 0, px[0], 0);

    // Run restored while draining must continue seamlessly
    run = 1'b1;
    repeat (85) @(negedge clk);
    run = 1'b0;
    repeat (12) @(negedge clk);
    run = 1'b1;
    repeat (30) @(negedge clk);

    // Reset mid-frame
    ok = 1'b0;
    for (waited = 0; waited < 200 && !ok; waited++) begin
      @(negedge clk);
      ok = px[0] == 3 && py[0] == 2;
    end
    chk("reach_3_2", 0, ok, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_running", 0, rn[0], 0);
    chk("async_rst_pos_y", 0, py[0], 0);
    chk("async_rst_h_sync", 0, hs[0], 1);
    chk("async_rst_h_sync_pol1", 1, hs[1], 0);
    chk("async_rst_pos_x", 2, px[2], 0);
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("restart_fs", 0, fs[0], 1);
    chk("restart_x", 0, px[0], 0);

    // Randomized strobe/run/reset
    for (k = 0; k < 20000; k++) begin
      @(negedge clk);
      pix_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) run = ~run;
      if ($urandom_range(0, 2999) == 0) begin
        #2 reset = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
      end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    begin
      int fcv [3];
      int nf;
      @(negedge clk);
      #2 reset = 1'b1;
      @(negedge clk);
      #2 reset = 1'b0; run = 1'b1; pix_en = 1'b1;
      nf = 0;
      for (waited = 0; waited < 400 && nf < 3; waited++) begin
        @(negedge clk);
        if (fs[0]) begin fcv[nf] = fc[0]; nf++; end
      end
      chk("fc_frames_seen", 0, nf, 3);
      chk("fc_first", 0, fcv[0], 1);
      chk("fc_second", 0, fcv[1], 2);
      chk("fc_third", 0, fcv[2], 3);
      ok = 1'b0;
      for (waited = 0; waited < 100 && !ok; waited++) begin
        @(negedge clk);
        ok = px[0] == 3;
      end
      #3 force dut0.frame_cnt = 16'hFFFF;
      fc_preset = 1'b1;
      @(posedge clk);
      #1 release dut0.frame_cnt;
      fc_preset = 1'b0;
      ok = 1'b0;
      for (waited = 0; waited < 100 && !ok; waited++) begin
        @(negedge clk);
        ok = fs[0];
      end
      chk("fc_wrap_seen", 0, ok, 1);
      chk("fc_wrap", 0, fc[0], 0);
    end
`endif

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
